// File: rtl/branch_unit.sv
// Resolves conditional branches against a target LUT and drives PC redirect (jumpEnable/jump/flush).
// Redirect one cycle after accept; accepts at most every other cycle, branch_valid dropped while busy.
module branch_unit #(
    parameter int ADDR_W    = 8,
    parameter int LUT_DEPTH = 16,
    parameter int IDX_W     = $clog2(LUT_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_valid,
    input  logic [1:0]        branch_cond,
    input  logic [IDX_W-1:0]  lut_index,
    input  logic              flag_zero,
    input  logic              flag_neg,
    input  logic [ADDR_W-1:0] count,
    input  logic              lut_we,
    input  logic [IDX_W-1:0]  lut_waddr,
    input  logic [ADDR_W-1:0] lut_wdata,
    output logic              jumpEnable,
    output logic [ADDR_W-1:0] jump,
    output logic              flush,
    output logic              busy,
    output logic [7:0]        taken_count
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_RESOLVE = 1'b1;

    localparam logic [1:0] C_ALWAYS     = 2'b00;
    localparam logic [1:0] C_IF_ZERO    = 2'b01;
    localparam logic [1:0] C_IF_NONZERO = 2'b10;
    localparam logic [1:0] C_IF_NEG     = 2'b11;

    logic [0:0]        state_q, state_d;
    logic [1:0]        cond_q, cond_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [7:0]        taken_cnt_q, taken_cnt_d;
    logic [ADDR_W-1:0] lut_q [LUT_DEPTH];

    logic              accept;
    logic              taken;
    logic              redirect;
    logic [ADDR_W-1:0] lut_rdata;

    assign accept = (state_q == S_IDLE) && branch_valid;

    // Write-first bypass so a same-cycle write to the looked-up entry is seen at accept.
    always_comb begin
        lut_rdata = lut_q[lut_index];
        if (lut_we && (lut_waddr == lut_index)) begin
            lut_rdata = lut_wdata;
        end
    end

    always_comb begin
        taken = 1'b0;
        case (cond_q)
            C_ALWAYS:     taken = 1'b1;
            C_IF_ZERO:    taken = zero_q;
            C_IF_NONZERO: taken = !zero_q;
            C_IF_NEG:     taken = neg_q;
            default:      taken = 1'b0;
        endcase
    end

    assign redirect = (state_q == S_RESOLVE) && taken && !reset;

    always_comb begin
        state_d     = S_IDLE;
        cond_d      = cond_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        target_d    = target_q;
        taken_cnt_d = taken_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_RESOLVE;
                    cond_d   = branch_cond;
                    zero_d   = flag_zero;
                    neg_d    = flag_neg;
                    target_d = lut_rdata;
                end
            end
            S_RESOLVE: begin
                state_d = S_IDLE;
                if (redirect && (taken_cnt_q != 8'hFF)) begin
                    taken_cnt_d = taken_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cond_q      <= 2'b00;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            target_q    <= '0;
            taken_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cond_q      <= cond_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            target_q    <= target_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_we) begin
            lut_q[lut_waddr] <= lut_wdata;
        end
    end

    // Offset wraps mod 2^ADDR_W so count + jump lands exactly on the target.
    assign jump        = redirect ? (target_q - count) : '0;
    assign jumpEnable  = redirect;
    assign flush       = redirect;
    assign busy        = (state_q == S_RESOLVE);
    assign taken_count = taken_cnt_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: drives at posedge+1, checks combinational outputs shortly after.
module tb_branch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       branch_valid;
    logic [1:0] branch_cond;
    logic [3:0] lut_index;
    logic       flag_zero;
    logic       flag_neg;
    logic [7:0] count;
    logic       lut_we;
    logic [3:0] lut_waddr;
    logic [7:0] lut_wdata;
    logic       jumpEnable;
    logic [7:0] jump;
    logic       flush;
    logic       busy;
    logic [7:0] taken_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_unit dut (
        .clk(clk), .reset(reset), .branch_valid(branch_valid), .branch_cond(branch_cond),
        .lut_index(lut_index), .flag_zero(flag_zero), .flag_neg(flag_neg), .count(count),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .jumpEnable(jumpEnable), .jump(jump), .flush(flush), .busy(busy),
        .taken_count(taken_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lut_write(input logic [3:0] a, input logic [7:0] d);
        lut_we = 1'b1; lut_waddr = a; lut_wdata = d;
        step();
        lut_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; branch_valid = 1'b0; branch_cond = 2'b00; lut_index = 4'd0;
        flag_zero = 1'b0; flag_neg = 1'b0; count = 8'h00;
        lut_we = 1'b0; lut_waddr = 4'd0; lut_wdata = 8'h00;
        step(); step();
        reset = 1'b0;
        #1;
        total++;
        if ({busy, jumpEnable, flush} !== 3'b000 || jump !== 8'h00 || taken_count !== 8'd0) begin
            bad++;
            $display("FAIL reset: busy=%b jE=%b flush=%b jump=%h taken=%0d required 0,0,0,00,0",
                     busy, jumpEnable, flush, jump, taken_count);
        end
    endtask

    task automatic test_always();
        logic [7:0] pc_next;
        lut_write(4'd3, 8'h40);
        branch_valid = 1'b1; branch_cond = 2'b00; lut_index = 4'd3;
        step();
        branch_valid = 1'b0; count = 8'h12;
        #1;
        pc_next = count + jump;
        total++;
        if ({busy, jumpEnable, flush} !== 3'b111 || jump !== 8'h2E || taken_count !== 8'd0) begin
            bad++;
            $display("FAIL always_redirect: busy=%b jE=%b flush=%b jump=%h taken=%0d required 1,1,1,2e,0",
                     busy, jumpEnable, flush, jump, taken_count);
        end
        total++;
        if (pc_next !== 8'h40) begin
            bad++;
            $display("FAIL always_pc_target: pc=%h required 40", pc_next);
        end
        step();
        total++;
        if ({busy, jumpEnable, flush} !== 3'b000 || taken_count !== 8'd1) begin
            bad++;
            $display("FAIL always_after: busy=%b jE=%b flush=%b taken=%0d required 0,0,0,1",
                     busy, jumpEnable, flush, taken_count);
        end
    endtask

    task automatic test_if_neg();
        lut_write(4'd5, 8'h02);
        branch_valid = 1'b1; branch_cond = 2'b11; lut_index = 4'd5; flag_neg = 1'b1;
        step();
        branch_valid = 1'b0; flag_neg = 1'b0; count = 8'h10;
        #1;
        total++;
        if (jumpEnable !== 1'b1 || jump !== 8'hF2) begin
            bad++;
            $display("FAIL if_neg_taken: jE=%b jump=%h required 1,f2", jumpEnable, jump);
        end
        step();
        branch_valid = 1'b1; branch_cond = 2'b11; lut_index = 4'd5; flag_neg = 1'b0;
        step();
        branch_valid = 1'b0;
        #1;
        total++;
        if ({busy, jumpEnable, flush} !== 3'b100 || jump !== 8'h00) begin
            bad++;
            $display("FAIL if_neg_not_taken: busy=%b jE=%b flush=%b jump=%h required 1,0,0,00",
                     busy, jumpEnable, flush, jump);
        end
        step();
        total++;
        if (taken_count !== 8'd2) begin
            bad++;
            $display("FAIL if_neg_count: taken=%0d required 2", taken_count);
        end
    endtask

    task automatic test_latched_flags();
        lut_write(4'd1, 8'h20);
        branch_valid = 1'b1; branch_cond = 2'b01; lut_index = 4'd1; flag_zero = 1'b1;
        step();
        branch_valid = 1'b0; flag_zero = 1'b0; count = 8'h05;
        #1;
        total++;
        if (jumpEnable !== 1'b1 || jump !== 8'h1B) begin
            bad++;
            $display("FAIL latched_zero: jE=%b jump=%h required 1,1b", jumpEnable, jump);
        end
        step();
        branch_valid = 1'b1; branch_cond = 2'b10; lut_index = 4'd1; flag_zero = 1'b1;
        step();
        branch_valid = 1'b0;
        #1;
        total++;
        if (jumpEnable !== 1'b0) begin
            bad++;
            $display("FAIL if_nonzero_with_zero: jE=%b required 0", jumpEnable);
        end
        step();
        flag_zero = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] busy_seen;
        int redirects;
        redirects = 0;
        branch_valid = 1'b1; branch_cond = 2'b00; lut_index = 4'd3; count = 8'h00;
        for (int i = 0; i < 4; i++) begin
            #1;
            busy_seen[i] = busy;
            if (jumpEnable === 1'b1) redirects++;
            step();
        end
        branch_valid = 1'b0;
        total++;
        if (busy_seen !== 4'b1010 || redirects != 2) begin
            bad++;
            $display("FAIL back_to_back: busy(c3..c0)=%b redirects=%0d required 1010,2",
                     busy_seen, redirects);
        end
        total++;
        if (taken_count !== 8'd5) begin
            bad++;
            $display("FAIL back_to_back_count: taken=%0d required 5", taken_count);
        end
    endtask

    task automatic test_bypass();
        lut_we = 1'b1; lut_waddr = 4'd7; lut_wdata = 8'h99;
        branch_valid = 1'b1; branch_cond = 2'b00; lut_index = 4'd7;
        step();
        branch_valid = 1'b0; count = 8'h90;
        lut_we = 1'b1; lut_waddr = 4'd7; lut_wdata = 8'h11;
        #1;
        total++;
        if (jumpEnable !== 1'b1 || jump !== 8'h09) begin
            bad++;
            $display("FAIL bypass_write_first: jE=%b jump=%h required 1,09", jumpEnable, jump);
        end
        step();
        lut_we = 1'b0;
        branch_valid = 1'b1; lut_index = 4'd7;
        step();
        branch_valid = 1'b0; count = 8'h11;
        #1;
        total++;
        if (jumpEnable !== 1'b1 || jump !== 8'h00) begin
            bad++;
            $display("FAIL self_loop: jE=%b jump=%h required 1,00", jumpEnable, jump);
        end
        step();
        total++;
        if (taken_count !== 8'd7) begin
            bad++;
            $display("FAIL bypass_count: taken=%0d required 7", taken_count);
        end
    endtask

    task automatic test_reset_in_resolve();
        branch_valid = 1'b1; branch_cond = 2'b00; lut_index = 4'd3;
        step();
        branch_valid = 1'b0; count = 8'h12; reset = 1'b1;
        #1;
        total++;
        if (jumpEnable !== 1'b0 || flush !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_resolve: jE=%b flush=%b required 0,0", jumpEnable, flush);
        end
        step();
        reset = 1'b0;
        #1;
        total++;
        if (taken_count !== 8'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_resolve_state: taken=%0d busy=%b required 0,0", taken_count, busy);
        end
        branch_valid = 1'b1; lut_index = 4'd3;
        step();
        branch_valid = 1'b0; count = 8'h12;
        #1;
        total++;
        if (jumpEnable !== 1'b1 || jump !== 8'hEE) begin
            bad++;
            $display("FAIL lut_cleared: jE=%b jump=%h required 1,ee", jumpEnable, jump);
        end
        step();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 260; i++) begin
            branch_valid = 1'b1; branch_cond = 2'b00;
            step();
            branch_valid = 1'b0;
            step();
            if (i == 253) begin
                total++;
                if (taken_count !== 8'd255) begin
                    bad++;
                    $display("FAIL saturate_reach: taken=%0d required 255", taken_count);
                end
            end
        end
        total++;
        if (taken_count !== 8'd255) begin
            bad++;
            $display("FAIL saturate_hold: taken=%0d required 255", taken_count);
        end
    endtask

    initial begin
        test_reset();
        test_always();
        test_if_neg();
        test_latched_flags();
        test_back_to_back();
        test_bypass();
        test_reset_in_resolve();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
